// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg: shared defaults and chunk sizing for the pipelined adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ----------------------------------------------------------------------------
// adder_chunk: combinational CHUNK-bit adder with carry in and carry out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

endmodule

`default_nettype wire

// File: rtl/adder_pipe.sv
// ----------------------------------------------------------------------------
// adder_pipe: carry-pipelined WIDTH-bit adder, one CHUNK per stage, valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe: WIDTH must be a positive multiple of STAGES");
  end

  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage k sees operand chunks k..STAGES-1 and result chunks 0..k-1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OPW  = (STAGES - k) * CHUNK;
    localparam int RESW = (k + 1) * CHUNK;

    logic [OPW-1:0]   ops_a;
    logic [OPW-1:0]   ops_b;
    logic             carry_in;
    logic             valid_in;
    logic [RESW-1:0]  res_d;
    logic [RESW-1:0]  res_q;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             carry_q;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign ops_a    = a;
      assign ops_b    = b;
      assign carry_in = c_in;
      assign valid_in = in_valid;
      assign res_d    = chunk_sum;
    end else begin : g_body
      assign ops_a    = g_stage[k-1].g_skew.a_q;
      assign ops_b    = g_stage[k-1].g_skew.b_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign res_d    = {chunk_sum, g_stage[k-1].res_q};
    end

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (ops_a[CHUNK-1:0]),
      .b     (ops_b[CHUNK-1:0]),
      .c_in  (carry_in),
      .sum   (chunk_sum),
      .c_out (chunk_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_in;
        carry_q <= chunk_cout;
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [OPW-CHUNK-1:0] a_q;
      logic [OPW-CHUNK-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= ops_a[OPW-1:CHUNK];
          b_q <= ops_b[OPW-1:CHUNK];
        end
      end
    end else begin : g_tail
      // The top operand chunk still carries both sign bits here.
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (ops_a[CHUNK-1] == ops_b[CHUNK-1]) &&
                   (chunk_sum[CHUNK-1] != ops_a[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign c_out     = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_adder_pipe: scoreboard bench for adder_pipe (WIDTH=16, STAGES=4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adder_pipe;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    int           issue;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         c;
    logic         o;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = 0;
  int   pidx = 0;
  bit [3:0] pat = 4'b1001;
  exp_t sb[$];

  vec_t dir[8] = '{
    '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
    '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1}
  };

  adder_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness changes just after the edge so it is stable at negedge.
  always @(posedge clk) begin
    #1;
    case (mode)
      1: begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input bit lat);
    exp_t e;
    logic [W:0] full;
    full    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum   = full[W-1:0];
    e.c     = full[W];
    e.o     = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    e.issue = 0;
    e.lat   = lat;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input exp_t e);
    int waited;
    waited = 0;
    @(negedge clk);
    a = ta;
    b = tb_;
    c_in = tc;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
    end else begin
      e.issue = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++;
        $display("FAIL in_ready in_ready=%b required=%b", in_ready,
                 !(out_valid && !out_ready));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result sum=%h c_out=%b ovf=%b required=none", sum, c_out, ovf);
        end else begin
          e = sb.pop_front();
          if (sum !== e.sum || c_out !== e.c || ovf !== e.o) begin
            failures++;
            $display("FAIL result sum=%h c_out=%b ovf=%b required sum=%h c_out=%b ovf=%b",
                     sum, c_out, ovf, e.sum, e.c, e.o);
          end
          if (e.lat) begin
            checks++;
            if (cyc - e.issue != S) begin
              failures++;
              $display("FAIL latency got=%0d required=%0d", cyc - e.issue, S);
            end
          end
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rc;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_c_out", c_out, 1'b0);
    check_bit("rst_ovf", ovf, 1'b0);
    check_bit("rst_sum_zero", sum == '0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready_after_rst", in_ready, 1'b1);

    // Directed vectors, isolated, with latency checks
    for (int i = 0; i < 8; i++) begin
      e = '{sum: dir[i].sum, c: dir[i].c, o: dir[i].o, issue: 0, lat: 1'b1};
      send(dir[i].a, dir[i].b, dir[i].ci, e);
      repeat (S + 1) @(negedge clk);
    end

    // Directed vectors back to back
    for (int i = 0; i < 8; i++) begin
      e = '{sum: dir[i].sum, c: dir[i].c, o: dir[i].o, issue: 0, lat: 1'b1};
      send(dir[i].a, dir[i].b, dir[i].ci, e);
    end
    repeat (S + 2) @(negedge clk);

    // Stream under 1,0,0,1 backpressure
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      e = '{sum: 16'(2 * i), c: 1'b0, o: 1'b0, issue: 0, lat: 1'b0};
      send(16'(i), 16'(i), 1'b0, e);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_bit("stream_drained", sb.size() == 0, 1'b1);

    // Reset mid-flight discards everything
    mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send(16'h0101, 16'h0202, 1'b0, model(16'h0101, 16'h0202, 1'b0, 1'b0));
    end
    #1 rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_sum_zero", sum == '0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_bit("midrst_no_output", out_valid, 1'b0);
      @(negedge clk);
    end

    // Random traffic against the arithmetic model
    mode = 2;
    for (int i = 0; i < 10000; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc, 1'b0));
    end

    mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_bit("final_drained", sb.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
